realign_stream_bidir: RTL

//  Streaming byte realigner with a runtime offset. Strips N leading bytes (STRIP) or prepends N zero bytes (INSERT).

---
 rtl/realign_stream_bidir.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/realign_stream_bidir.sv
// Byte realigner: strips N leading bytes (STRIP) or prepends N zero bytes (INSERT) per packet; REALIGN_MASK_EN zeroes invalid tail bytes.
// Latency: one cycle from input accept to registered output beat; one extra flush beat when the tail spills over.
// Backpressure: src_rdy = !FLUSH && (!dst_val || dst_rdy); output and hold freeze while dst_rdy is low.
module realign_stream_bidir #(
    parameter int DATA_W     = 512,
    parameter int DATA_BYTES = DATA_W / 8,
    parameter int PAD_W      = $clog2(DATA_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              realign_mode,
    input  logic [PAD_W-1:0]  realign_bytes,
    input  logic              src_realign_data_val,
    input  logic [DATA_W-1:0] src_realign_data,
    input  logic [PAD_W-1:0]  src_realign_data_padbytes,
    input  logic              src_realign_data_last,
    output logic              realign_src_data_rdy,
    output logic              realign_dst_data_val,
    output logic [DATA_W-1:0] realign_dst_data,
    output logic [PAD_W-1:0]  realign_dst_data_padbytes,
    output logic              realign_dst_data_last,
    input  logic              dst_realign_data_rdy,
    output logic              realign_err
);

    localparam int CW = PAD_W + 2;
    localparam logic [CW-1:0]  B_C = CW'(DATA_BYTES);
    localparam logic [PAD_W:0] B_S = (PAD_W + 1)'(DATA_BYTES);

    typedef enum logic [1:0] {ST_FIRST, ST_STREAM, ST_FLUSH} state_t;

    // Output window: B bytes starting at byte s of {hi, lo}, byte 0 at the MSB.
    function automatic logic [DATA_W-1:0] window(input logic [DATA_W-1:0] hi,
                                                 input logic [DATA_W-1:0] lo,
                                                 input logic [PAD_W:0]    s);
        logic [2*DATA_W-1:0] cat;
        cat = {hi, lo} << {s, 3'b000};
        return cat[2*DATA_W-1 -: DATA_W];
    endfunction

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                ins_q, ins_d;
    logic [PAD_W-1:0]    n_q, n_d;
    logic [PAD_W-1:0]    flush_pad_q, flush_pad_d;
    logic                run_q;
    logic                dst_val_q, dst_val_d;
    logic [DATA_W-1:0]   dst_data_q, dst_data_d, data_nxt;
    logic [PAD_W-1:0]    dst_pad_q, dst_pad_d;
    logic                dst_last_q, dst_last_d;
    logic                err_q, err_d;

    logic                can_load, acc, first, cur_ins;
    logic [PAD_W-1:0]    cur_n;
    logic [PAD_W:0]      shamt;
    logic [CW-1:0]       v, npv;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        ins_d       = ins_q;
        n_d         = n_q;
        flush_pad_d = flush_pad_q;
        dst_val_d   = dst_val_q;
        data_nxt    = dst_data_q;
        dst_pad_d   = dst_pad_q;
        dst_last_d  = dst_last_q;
        err_d       = err_q;

        can_load             = !dst_val_q || dst_realign_data_rdy;
        realign_src_data_rdy = run_q && (state_q != ST_FLUSH) && can_load;
        acc                  = src_realign_data_val && realign_src_data_rdy;
        first                = (state_q == ST_FIRST);
        cur_n                = first ? realign_bytes : n_q;
        // N=0 behaves as a zero-byte insert so STRIP N=0 is a plain pass-through.
        cur_ins              = first ? (realign_mode || (realign_bytes == '0)) : ins_q;
        shamt                = cur_ins ? (B_S - {1'b0, cur_n}) : {1'b0, cur_n};
        v                    = B_C - CW'(src_realign_data_padbytes);
        npv                  = CW'(cur_n) + v;

        if (can_load) begin
            dst_val_d = 1'b0;
            err_d     = 1'b0;
        end

        if (state_q == ST_FLUSH && can_load) begin
            dst_val_d  = 1'b1;
            data_nxt   = window(hold_q, '0, shamt);
            dst_pad_d  = flush_pad_q;
            dst_last_d = 1'b1;
            state_d    = ST_FIRST;
        end

        if (acc) begin
            hold_d = src_realign_data;
            if (first) begin
                ins_d = cur_ins;
                n_d   = cur_n;
            end
            if (cur_ins) begin
                dst_val_d  = 1'b1;
                data_nxt   = window(first ? '0 : hold_q, src_realign_data, shamt);
                dst_last_d = 1'b0;
                dst_pad_d  = '0;
                state_d    = ST_STREAM;
                if (src_realign_data_last) begin
                    if (npv > B_C) begin
                        state_d     = ST_FLUSH;
                        flush_pad_d = PAD_W'((B_C << 1) - npv);
                    end else begin
                        state_d    = ST_FIRST;
                        dst_last_d = 1'b1;
                        dst_pad_d  = PAD_W'(B_C - npv);
                    end
                end
            end else if (first) begin
                state_d = ST_STREAM;
                if (src_realign_data_last) begin
                    state_d    = ST_FIRST;
                    dst_val_d  = 1'b1;
                    dst_last_d = 1'b1;
                    if (v > CW'(cur_n)) begin
                        data_nxt  = window(src_realign_data, '0, shamt);
                        dst_pad_d = PAD_W'(B_C - (v - CW'(cur_n)));
                    end else begin
                        data_nxt  = '0;
                        dst_pad_d = PAD_W'(B_C - 1'b1);
                        err_d     = 1'b1;
                    end
                end
            end else begin
                dst_val_d  = 1'b1;
                data_nxt   = window(hold_q, src_realign_data, shamt);
                dst_last_d = 1'b0;
                dst_pad_d  = '0;
                if (src_realign_data_last) begin
                    if (v > CW'(cur_n)) begin
                        state_d     = ST_FLUSH;
                        flush_pad_d = PAD_W'(B_C - v + CW'(cur_n));
                    end else begin
                        state_d    = ST_FIRST;
                        dst_last_d = 1'b1;
                        dst_pad_d  = PAD_W'(CW'(cur_n) - v);
                    end
                end
            end
        end

        dst_data_d = data_nxt;
`ifdef REALIGN_MASK_EN
        if (dst_last_d) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (i >= DATA_BYTES - int'(dst_pad_d)) dst_data_d[DATA_W-1-8*i -: 8] = 8'h00;
            end
        end
`else
        dst_data_d = data_nxt;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FIRST;
            hold_q      <= '0;
            ins_q       <= 1'b0;
            n_q         <= '0;
            flush_pad_q <= '0;
            run_q       <= 1'b0;
            dst_val_q   <= 1'b0;
            dst_data_q  <= '0;
            dst_pad_q   <= '0;
            dst_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            ins_q       <= ins_d;
            n_q         <= n_d;
            flush_pad_q <= flush_pad_d;
            run_q       <= 1'b1;
            dst_val_q   <= dst_val_d;
            dst_data_q  <= dst_data_d;
            dst_pad_q   <= dst_pad_d;
            dst_last_q  <= dst_last_d;
            err_q       <= err_d;
        end
    end

    assign realign_dst_data_val      = dst_val_q;
    assign realign_dst_data          = dst_data_q;
    assign realign_dst_data_padbytes = dst_pad_q;
    assign realign_dst_data_last     = dst_last_q;
    assign realign_err               = err_q;

endmodule
